// File: rtl/sfifo_param.sv
// Parametrised single-clock FIFO with occupancy count, threshold flags and sticky error flags.
// Latency: read data on data_out one cycle after an accepted read; flags track count same cycle.
// Backpressure: full rejects writes unless a read is accepted the same cycle; empty rejects reads.
module sfifo_param #(
   parameter int DATA_W    = 8,
   parameter int DEPTH     = 8,
   parameter int AF_THRESH = DEPTH - 2,
   parameter int AE_THRESH = 1
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       write_e,
   input  logic                       read_e,
   input  logic                       err_clr,
   input  logic [DATA_W-1:0]          data_in,
   output logic [DATA_W-1:0]          data_out,
   output logic                       rd_valid,
   output logic                       full,
   output logic                       empty,
   output logic                       almost_full,
   output logic                       almost_empty,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       overflow,
   output logic                       underflow
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [DATA_W-1:0] mem [DEPTH];
   logic [PW-1:0]     wr_ptr;
   logic [PW-1:0]     rd_ptr;
   logic              rd_acc;
   logic              wr_acc;
   logic [CW-1:0]     count_nxt;

   // A full FIFO may still take a write when a read frees a slot in the same cycle.
   assign rd_acc = read_e & ~empty;
   assign wr_acc = write_e & (~full | rd_acc);

   always_comb begin
      count_nxt = count;
      case ({wr_acc, rd_acc})
         2'b10:   count_nxt = count + CW'(1);
         2'b01:   count_nxt = count - CW'(1);
         default: count_nxt = count;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset && wr_acc)
         mem[wr_ptr] <= data_in;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         count        <= '0;
         empty        <= 1'b1;
         full         <= 1'b0;
         almost_empty <= 1'b1;
         almost_full  <= 1'b0;
         data_out     <= '0;
         rd_valid     <= 1'b0;
         overflow     <= 1'b0;
         underflow    <= 1'b0;
      end else begin
         if (wr_acc)
            wr_ptr <= wr_ptr + PW'(1);
         if (rd_acc) begin
            rd_ptr   <= rd_ptr + PW'(1);
            data_out <= mem[rd_ptr];
         end
         rd_valid     <= rd_acc;
         count        <= count_nxt;
         empty        <= (count_nxt == '0);
         full         <= (count_nxt == CW'(DEPTH));
         almost_full  <= (count_nxt >= CW'(AF_THRESH));
         almost_empty <= (count_nxt <= CW'(AE_THRESH));
         // Set beats clear when both happen in one cycle.
         overflow     <= (write_e & ~wr_acc) | (overflow  & ~err_clr);
         underflow    <= (read_e  & ~rd_acc) | (underflow & ~err_clr);
      end
   end
endmodule

// File: tb/tb_sfifo_param.sv
// Directed bench for sfifo_param (DATA_W=8, DEPTH=8, AF_THRESH=6, AE_THRESH=1).
module tb_sfifo_param;
   logic       clk = 1'b0;
   logic       reset, write_e, read_e, err_clr;
   logic [7:0] data_in, data_out;
   logic       rd_valid, full, empty, almost_full, almost_empty, overflow, underflow;
   logic [3:0] count;
   int         checks = 0;
   int         errors = 0;

   sfifo_param #(.DATA_W(8), .DEPTH(8), .AF_THRESH(6), .AE_THRESH(1)) dut (
      .clk(clk), .reset(reset), .write_e(write_e), .read_e(read_e), .err_clr(err_clr),
      .data_in(data_in), .data_out(data_out), .rd_valid(rd_valid), .full(full),
      .empty(empty), .almost_full(almost_full), .almost_empty(almost_empty),
      .count(count), .overflow(overflow), .underflow(underflow)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Occupancy plus the four flags that follow from it.
   task automatic chk_cnt(input string tag, input int c);
      chk({tag, ".count"}, int'(count), c);
      chk({tag, ".empty"}, int'(empty), (c == 0) ? 1 : 0);
      chk({tag, ".full"}, int'(full), (c == 8) ? 1 : 0);
      chk({tag, ".almost_full"}, int'(almost_full), (c >= 6) ? 1 : 0);
      chk({tag, ".almost_empty"}, int'(almost_empty), (c <= 1) ? 1 : 0);
   endtask

   task automatic chk_rd(input string tag, input int d, input int v);
      chk({tag, ".data_out"}, int'(data_out), d);
      chk({tag, ".rd_valid"}, int'(rd_valid), v);
   endtask

   task automatic cyc(input logic w, input logic r, input logic c, input logic [7:0] d);
      write_e = w;
      read_e  = r;
      err_clr = c;
      data_in = d;
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [7:0] pat [8];
      pat = '{8'h03, 8'h09, 8'h07, 8'h03, 8'h09, 8'h07, 8'h03, 8'h09};

      // 1. reset with a write pending
      reset = 1'b1;
      cyc(1'b1, 1'b0, 1'b0, 8'hFF);
      cyc(1'b1, 1'b0, 1'b0, 8'hFF);
      chk_cnt("reset", 0);
      chk_rd("reset", 0, 0);
      chk("reset.overflow", int'(overflow), 0);
      chk("reset.underflow", int'(underflow), 0);
      reset = 1'b0;

      // 2. fill then overflow
      for (int i = 0; i < 8; i++) begin
         cyc(1'b1, 1'b0, 1'b0, pat[i]);
         chk_cnt($sformatf("fill%0d", i), i + 1);
      end
      cyc(1'b1, 1'b0, 1'b0, 8'h17);
      chk_cnt("ovf_write", 8);
      chk("ovf_write.overflow", int'(overflow), 1);

      // 3. drain then underflow
      for (int i = 0; i < 8; i++) begin
         cyc(1'b0, 1'b1, 1'b0, 8'h00);
         chk_rd($sformatf("drain%0d", i), int'(pat[i]), 1);
         chk_cnt($sformatf("drain%0d", i), 7 - i);
      end
      cyc(1'b0, 1'b1, 1'b0, 8'h00);
      chk_rd("unf_read", 8'h09, 0);
      chk("unf_read.underflow", int'(underflow), 1);
      chk_cnt("unf_read", 0);

      cyc(1'b0, 1'b0, 1'b1, 8'h00);
      chk("clr.overflow", int'(overflow), 0);
      chk("clr.underflow", int'(underflow), 0);

      // 4a. simultaneous read/write at full
      for (int i = 0; i < 8; i++) cyc(1'b1, 1'b0, 1'b0, 8'h20 + 8'(i));
      chk_cnt("full_again", 8);
      cyc(1'b1, 1'b1, 1'b0, 8'hAA);
      chk_rd("rw_full", 8'h20, 1);
      chk_cnt("rw_full", 8);
      chk("rw_full.overflow", int'(overflow), 0);
      for (int i = 1; i < 8; i++) begin
         cyc(1'b0, 1'b1, 1'b0, 8'h00);
         chk_rd($sformatf("rw_drain%0d", i), 8'h20 + i, 1);
      end
      cyc(1'b0, 1'b1, 1'b0, 8'h00);
      chk_rd("rw_last", 8'hAA, 1);
      chk_cnt("rw_last", 0);

      // 4b. simultaneous read/write at empty: no bypass
      cyc(1'b1, 1'b1, 1'b0, 8'h55);
      chk_cnt("rw_empty", 1);
      chk("rw_empty.underflow", int'(underflow), 1);
      chk_rd("rw_empty", 8'hAA, 0);
      cyc(1'b0, 1'b1, 1'b0, 8'h00);
      chk_rd("rw_empty_rd", 8'h55, 1);
      chk_cnt("rw_empty_rd", 0);

      // 5. wrap-around
      for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 1'b0, 8'h30 + 8'(i));
      chk_cnt("wrap_w5", 5);
      for (int i = 0; i < 5; i++) begin
         cyc(1'b0, 1'b1, 1'b0, 8'h00);
         chk_rd($sformatf("wrap_r5_%0d", i), 8'h30 + i, 1);
      end
      for (int i = 0; i < 8; i++) cyc(1'b1, 1'b0, 1'b0, 8'h10 + 8'(i));
      chk_cnt("wrap_w8", 8);
      for (int i = 0; i < 8; i++) begin
         cyc(1'b0, 1'b1, 1'b0, 8'h00);
         chk_rd($sformatf("wrap_r8_%0d", i), 8'h10 + i, 1);
      end
      chk_cnt("wrap_done", 0);

      // 6. err_clr and mid-operation reset
      for (int i = 0; i < 8; i++) cyc(1'b1, 1'b0, 1'b0, 8'h40 + 8'(i));
      cyc(1'b1, 1'b0, 1'b0, 8'hEE);
      chk("e6_ovf.overflow", int'(overflow), 1);
      cyc(1'b0, 1'b0, 1'b1, 8'h00);
      chk("e6_clr.overflow", int'(overflow), 0);
      chk("e6_clr.underflow", int'(underflow), 0);
      cyc(1'b1, 1'b0, 1'b1, 8'hEE);
      chk("e6_setwins.overflow", int'(overflow), 1);
      chk_cnt("e6_setwins", 8);
      for (int i = 0; i < 4; i++) begin
         cyc(1'b0, 1'b1, 1'b0, 8'h00);
         chk_rd($sformatf("e6_rd%0d", i), 8'h40 + i, 1);
      end
      chk_cnt("e6_cnt4", 4);
      reset = 1'b1;
      cyc(1'b0, 1'b1, 1'b0, 8'h00);
      reset = 1'b0;
      chk_cnt("midreset", 0);
      chk_rd("midreset", 0, 0);
      chk("midreset.overflow", int'(overflow), 0);
      chk("midreset.underflow", int'(underflow), 0);
      cyc(1'b1, 1'b0, 1'b0, 8'h5A);
      cyc(1'b0, 1'b1, 1'b0, 8'h00);
      chk_rd("post_reset", 8'h5A, 1);
      chk_cnt("post_reset", 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
